// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The requester (master) drives start and the operands; the divider (slave)
// returns status and results.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Operands are latched when start is accepted (IDLE or DONE); results load on
// entry to DONE and are held until the next completion. A zero divisor skips
// the iteration and completes in one cycle with the div_by_zero flag set.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_restoring_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    // Partial remainder is always < divisor after each step, so its top bit
    // (the WIDTH+1'th) is always zero between cycles and is not stored.
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_pshift;
    logic [WIDTH:0]   w_t;
    logic [WIDTH-1:0] w_pnext;
    logic [WIDTH-1:0] w_qnext;

    assign w_accept = bus.start && (r_state != RUN);
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // One restoring step: shift in the next dividend bit, trial-subtract,
    // keep the difference only if it did not go negative.
    assign w_pshift = {r_p, r_q[WIDTH-1]};
    assign w_t      = w_pshift - {1'b0, r_d};
    assign w_pnext  = w_t[WIDTH] ? w_pshift[WIDTH-1:0] : w_t[WIDTH-1:0];
    assign w_qnext  = {r_q[WIDTH-2:0], ~w_t[WIDTH]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; DONE behaves like IDLE for acceptance (back-to-back).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) w_next = (bus.divisor == '0) ? DONE : RUN;
                else          w_next = IDLE;
            end
            RUN:     if (w_last) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_count <= '0;
            r_p     <= '0;
            r_q     <= bus.dividend;
            r_d     <= bus.divisor;
            if (bus.divisor == '0) begin
                r_quot <= '1;
                r_rem  <= bus.dividend;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_count <= r_count + 1'b1;
            r_p     <= w_pnext;
            r_q     <= w_qnext;
            if (w_last) begin
                r_quot <= w_qnext;
                r_rem  <= w_pnext;
                r_dbz  <= 1'b0;
            end
        end
    end

    assign bus.busy        = (r_state == RUN);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule
